// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, the jr function code and instruction field widths.
package mips_pkg;

    localparam int OPCODE_W  = 6;
    localparam int FUNCT_W   = 6;
    localparam int REG_IDX_W = 5;
    localparam int SHAMT_W   = 5;
    localparam int IMM_W     = 16;
    localparam int TARGET_W  = 26;
    localparam int INSTR_W   = 32;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;

    localparam logic [FUNCT_W-1:0]  FUNCT_JR = 6'b001000;

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one synchronous write port, asynchronous active-low clear, and $0 hardwired to zero.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] i_ra1,
    input  logic [REG_IDX_W-1:0] i_ra2,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_wa,
    input  logic [DATA_W-1:0]    i_wd,
    output logic [DATA_W-1:0]    o_rd1,
    output logic [DATA_W-1:0]    o_rd2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we_valid;

    assign w_we_valid = i_we && (i_wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_valid) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Bypass lets writeback and decode share a cycle without a split-phase register file.
    always_comb begin
        o_rd1 = r_regs[i_ra1];
        if (i_ra1 == '0) begin
            o_rd1 = '0;
        end else if (w_we_valid && (i_wa == i_ra1)) begin
            o_rd1 = i_wd;
        end
    end

    always_comb begin
        o_rd2 = r_regs[i_ra2];
        if (i_ra2 == '0) begin
            o_rd2 = '0;
        end else if (w_we_valid && (i_wa == i_ra2)) begin
            o_rd2 = i_wd;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register with stall/flush, register file, operand
// forwarding for the early compare, and branch/jump/jr resolution back to fetch.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W-1:0]   instr_f,
    input  logic [DATA_W-1:0]    pc_plus_4_f,
    input  logic                 stall_d,
    input  logic                 forward_a_d,
    input  logic                 forward_b_d,
    input  logic [DATA_W-1:0]    alu_out_m,
    input  logic                 reg_write_w,
    input  logic [REG_IDX_W-1:0] write_reg_w,
    input  logic [DATA_W-1:0]    result_w,
    output logic [INSTR_W-1:0]   instr_d,
    output logic [DATA_W-1:0]    pc_plus_4_d,
    output logic [DATA_W-1:0]    rd1_d,
    output logic [DATA_W-1:0]    rd2_d,
    output logic [DATA_W-1:0]    sign_imm_d,
    output logic [REG_IDX_W-1:0] rs_d,
    output logic [REG_IDX_W-1:0] rt_d,
    output logic [REG_IDX_W-1:0] rd_d,
    output logic                 branch,
    output logic                 jump,
    output logic                 jump_reg,
    output logic [DATA_W-1:0]    branch_addr,
    output logic [DATA_W-1:0]    jump_addr,
    output logic [DATA_W-1:0]    jump_reg_addr
);

    logic [INSTR_W-1:0]  r_instr;
    logic [DATA_W-1:0]   r_pc_plus_4;
    logic                r_valid;

    logic                w_flush;
    logic                w_active;
    logic                w_eq;
    logic [DATA_W-1:0]   w_cmp_a;
    logic [DATA_W-1:0]   w_cmp_b;
    logic [OPCODE_W-1:0] w_op;
    logic [FUNCT_W-1:0]  w_funct;

    // IF/ID register: stall outranks flush so a stalled redirect is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr     <= '0;
            r_pc_plus_4 <= '0;
            r_valid     <= 1'b0;
        end else if (!stall_d) begin
            if (w_flush) begin
                r_instr     <= '0;
                r_pc_plus_4 <= '0;
                r_valid     <= 1'b0;
            end else begin
                r_instr     <= instr_f;
                r_pc_plus_4 <= pc_plus_4_f;
                r_valid     <= 1'b1;
            end
        end
    end

    assign instr_d     = r_instr;
    assign pc_plus_4_d = r_pc_plus_4;
    assign w_op        = r_instr[31:26];
    assign w_funct     = r_instr[5:0];
    assign rs_d        = r_instr[25:21];
    assign rt_d        = r_instr[20:16];
    assign rd_d        = r_instr[15:11];
    assign sign_imm_d  = {{(DATA_W-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (rs_d),
        .i_ra2 (rt_d),
        .i_we  (reg_write_w),
        .i_wa  (write_reg_w),
        .i_wd  (result_w),
        .o_rd1 (rd1_d),
        .o_rd2 (rd2_d)
    );

    assign w_cmp_a  = forward_a_d ? alu_out_m : rd1_d;
    assign w_cmp_b  = forward_b_d ? alu_out_m : rd2_d;
    assign w_eq     = (w_cmp_a == w_cmp_b);
    assign w_active = r_valid && !stall_d;

    always_comb begin
        branch   = 1'b0;
        jump     = 1'b0;
        jump_reg = 1'b0;
        if (w_active) begin
            case (w_op)
                OP_BEQ:   branch   = w_eq;
                OP_BNE:   branch   = !w_eq;
                OP_J,
                OP_JAL:   jump     = 1'b1;
                OP_RTYPE: jump_reg = (w_funct == FUNCT_JR);
                default: ;
            endcase
        end
    end

    assign w_flush       = branch | jump | jump_reg;
    assign branch_addr   = r_pc_plus_4 + {sign_imm_d[DATA_W-3:0], 2'b00};
    assign jump_addr     = {r_pc_plus_4[DATA_W-1:DATA_W-4], r_instr[TARGET_W-1:0], 2'b00};
    assign jump_reg_addr = w_cmp_a;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the decode stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_f, pc_plus_4_f, alu_out_m, result_w;
    logic        stall_d, forward_a_d, forward_b_d, reg_write_w;
    logic [4:0]  write_reg_w;
    logic [31:0] instr_d, pc_plus_4_d, rd1_d, rd2_d, sign_imm_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic        branch, jump, jump_reg;
    logic [31:0] branch_addr, jump_addr, jump_reg_addr;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_f       (instr_f),
        .pc_plus_4_f   (pc_plus_4_f),
        .stall_d       (stall_d),
        .forward_a_d   (forward_a_d),
        .forward_b_d   (forward_b_d),
        .alu_out_m     (alu_out_m),
        .reg_write_w   (reg_write_w),
        .write_reg_w   (write_reg_w),
        .result_w      (result_w),
        .instr_d       (instr_d),
        .pc_plus_4_d   (pc_plus_4_d),
        .rd1_d         (rd1_d),
        .rd2_d         (rd2_d),
        .sign_imm_d    (sign_imm_d),
        .rs_d          (rs_d),
        .rt_d          (rt_d),
        .rd_d          (rd_d),
        .branch        (branch),
        .jump          (jump),
        .jump_reg      (jump_reg),
        .branch_addr   (branch_addr),
        .jump_addr     (jump_addr),
        .jump_reg_addr (jump_reg_addr)
    );

    typedef struct {
        logic [31:0] instr, pc4, rd1, rd2, simm, baddr, jaddr, jraddr;
        logic [4:0]  rs, rt, rd;
        logic        br, j, jr;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc4;
    bit          m_valid;
    bit          m_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'd0;
        if (reg_write_w && (int'(write_reg_w) == idx)) return result_w;
        return m_regs[idx];
    endfunction

    // Evaluate the model for the inputs now on the pins and queue the expected outputs.
    task automatic apply();
        exp_t e;
        int op, funct, imm;
        logic [31:0] a, b;
        bit live;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end
        op    = int'(m_instr >> 26);
        funct = int'(m_instr % 64);
        imm   = int'(m_instr % 65536);
        if (imm >= 32768) imm = imm - 65536;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.rs    = 5'((m_instr >> 21) % 32);
        e.rt    = 5'((m_instr >> 16) % 32);
        e.rd    = 5'((m_instr >> 11) % 32);
        e.rd1   = m_read(int'(e.rs));
        e.rd2   = m_read(int'(e.rt));
        e.simm  = 32'(imm);
        a = forward_a_d ? alu_out_m : e.rd1;
        b = forward_b_d ? alu_out_m : e.rd2;
        live = m_valid && !stall_d;
        e.br  = live && ((op == 4 && a == b) || (op == 5 && a != b));
        e.j   = live && (op == 2 || op == 3);
        e.jr  = live && op == 0 && funct == 8;
        e.baddr  = m_pc4 + 32'(imm * 4);
        e.jaddr  = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        e.jraddr = a;
        m_flush = e.br || e.j || e.jr;
        q.push_back(e);
    endtask

    // Advance the model across the coming rising edge, then wait for the next drive slot.
    task automatic next();
        if (rst_n) begin
            if (reg_write_w && write_reg_w != 0) m_regs[write_reg_w] = result_w;
            if (!stall_d) begin
                if (m_flush) begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                end else begin
                    m_instr = instr_f; m_pc4 = pc_plus_4_f; m_valid = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wreg(input logic [4:0] idx, input logic [31:0] val);
        reg_write_w = 1'b1; write_reg_w = idx; result_w = val;
        apply(); next();
        reg_write_w = 1'b0;
    endtask

    // Monitor: outputs are valid every cycle, sampled mid low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("instr_d", instr_d, e.instr);
                chk("pc_plus_4_d", pc_plus_4_d, e.pc4);
                chk("rd1_d", rd1_d, e.rd1);
                chk("rd2_d", rd2_d, e.rd2);
                chk("sign_imm_d", sign_imm_d, e.simm);
                chk("rs_d", 32'(rs_d), 32'(e.rs));
                chk("rt_d", 32'(rt_d), 32'(e.rt));
                chk("rd_d", 32'(rd_d), 32'(e.rd));
                chk("branch", 32'(branch), 32'(e.br));
                chk("jump", 32'(jump), 32'(e.j));
                chk("jump_reg", 32'(jump_reg), 32'(e.jr));
                chk("branch_addr", branch_addr, e.baddr);
                chk("jump_addr", jump_addr, e.jaddr);
                chk("jump_reg_addr", jump_reg_addr, e.jraddr);
            end
        end
    end

    initial begin
        logic [31:0] vals [4];
        rst_n = 1'b0; instr_f = 0; pc_plus_4_f = 0; stall_d = 0;
        forward_a_d = 0; forward_b_d = 0; alu_out_m = 0;
        reg_write_w = 0; write_reg_w = 0; result_w = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_instr = 0; m_pc4 = 0; m_valid = 0; m_flush = 0;
        @(negedge clk);
        apply(); next();
        apply(); next();
        rst_n = 1'b1;

        wreg(5'd1, 32'd7);
        wreg(5'd2, 32'd7);
        wreg(5'd31, 32'h0000_0120);

        // Write-through: add $6,$5,$0 in decode while $5 is written back
        instr_f = 32'h00A0_3020; pc_plus_4_f = 32'h4;
        apply(); next();
        reg_write_w = 1; write_reg_w = 5; result_w = 32'h1234_5678;
        apply(); #3 chk("wt_rd1", rd1_d, 32'h1234_5678); next();
        write_reg_w = 0; result_w = 32'hFFFF_FFFF;
        apply(); #3 chk("r0_write_rd2", rd2_d, 32'h0); next();
        reg_write_w = 0;
        apply(); #3 chk("r0_after_rd2", rd2_d, 32'h0); next();

        // beq $1,$2,-2 taken, then flushed
        instr_f = 32'h1022_FFFE; pc_plus_4_f = 32'h40;
        apply(); next();
        instr_f = 32'h2008_0001; pc_plus_4_f = 32'h44;
        apply(); #3 chk("beq_branch", 32'(branch), 32'd1); chk("beq_addr", branch_addr, 32'h38); next();
        instr_f = 32'h0;
        apply(); #3 chk("beq_flush", instr_d, 32'h0); next();

        // bne $3,$0,+1 with and without rs forwarding
        instr_f = 32'h1460_0001; pc_plus_4_f = 32'h100;
        apply(); next();
        alu_out_m = 32'd9; forward_a_d = 1; instr_f = 0;
        apply(); #3 chk("bne_fwd_branch", 32'(branch), 32'd1); chk("bne_fwd_addr", branch_addr, 32'h104); next();
        forward_a_d = 0; instr_f = 32'h1460_0001;
        apply(); next();
        instr_f = 0;
        apply(); #3 chk("bne_nofwd_branch", 32'(branch), 32'd0); next();

        // j and jr
        instr_f = 32'h0810_0000; pc_plus_4_f = 32'h9000_0004;
        apply(); next();
        instr_f = 0;
        apply(); #3 chk("j_jump", 32'(jump), 32'd1); chk("j_addr", jump_addr, 32'h9040_0000); next();
        instr_f = 32'h03E0_0008;
        apply(); next();
        instr_f = 0;
        apply(); #3 chk("jr_jump_reg", 32'(jump_reg), 32'd1); chk("jr_addr", jump_reg_addr, 32'h120); next();

        // Stall held over a taken beq
        instr_f = 32'h1022_FFFE; pc_plus_4_f = 32'h40;
        apply(); next();
        stall_d = 1; instr_f = 32'hDEAD_BEEF;
        repeat (2) begin
            apply(); #3 chk("stall_branch", 32'(branch), 32'd0); chk("stall_instr", instr_d, 32'h1022_FFFE); next();
        end
        stall_d = 0;
        apply(); #3 chk("unstall_branch", 32'(branch), 32'd1); next();
        instr_f = 0;
        apply(); #3 chk("unstall_flush", instr_d, 32'h0); next();

        // Asynchronous reset mid-stream
        instr_f = 32'h1000_0003;
        apply(); next();
        rst_n = 0;
        apply(); #3
        chk("rst_instr", instr_d, 32'h0); chk("rst_rd1", rd1_d, 32'h0); chk("rst_rd2", rd2_d, 32'h0);
        chk("rst_br", 32'({branch, jump, jump_reg}), 32'd0);
        next();
        rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rs, rt;
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            vals[0] = 32'd0; vals[1] = 32'd7; vals[2] = 32'hFFFF_FFFF; vals[3] = $urandom;
            case ($urandom_range(0, 6))
                0: instr_f = {6'b000100, rs, rt, 16'($urandom)};
                1: instr_f = {6'b000101, rs, rt, 16'($urandom)};
                2: instr_f = {6'b000010, 26'($urandom)};
                3: instr_f = {6'b000011, 26'($urandom)};
                4: instr_f = {6'b000000, rs, 15'($urandom), 6'b001000};
                5: instr_f = {6'b000000, rs, rt, 10'($urandom), 6'($urandom)};
                default: instr_f = $urandom;
            endcase
            pc_plus_4_f = $urandom & 32'hFFFF_FFFC;
            stall_d     = ($urandom_range(0, 4) == 0);
            forward_a_d = ($urandom_range(0, 3) == 0);
            forward_b_d = ($urandom_range(0, 3) == 0);
            alu_out_m   = vals[$urandom_range(0, 3)];
            reg_write_w = ($urandom_range(0, 1) == 0);
            write_reg_w = 5'($urandom_range(0, 7));
            result_w    = vals[$urandom_range(0, 3)];
            rst_n       = ($urandom_range(0, 63) != 0);
            apply(); next();
        end
        rst_n = 1; reg_write_w = 0; stall_d = 0;

        #5;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of fetch in the 5-stage MIPS core.
- Contains the IF/ID pipeline register with stall and flush, the 32x32 register file, and early branch/jump resolution.
- Returns branch_addr, jump_addr, jump_reg_addr and the branch/jump/jump_reg selects to fetch.
- Presents operands, immediate and register fields to the ID/EX register.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register-file depth; index width is 5 bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- instr_f  in  32  instruction from fetch.
- pc_plus_4_f  in  32  PC+4 from fetch.
- stall_d  in  1  hazard-unit stall; IF/ID holds when 1.
- forward_a_d  in  1  select alu_out_m for the rs compare/jr operand.
- forward_b_d  in  1  select alu_out_m for the rt compare operand.
- alu_out_m  in  32  memory-stage ALU result for forwarding.
- reg_write_w  in  1  writeback enable.
- write_reg_w  in  5  writeback destination.
- result_w  in  32  writeback data.
- instr_d  out  32  registered instruction.
- pc_plus_4_d  out  32  registered PC+4.
- rd1_d, rd2_d  out  32  register-file reads for rs and rt (not forwarded).
- sign_imm_d  out  32  sign-extended instr_d[15:0].
- rs_d, rt_d, rd_d  out  5  instr_d[25:21], [20:16], [15:11].
- branch  out  1  taken beq/bne.
- jump  out  1  j or jal.
- jump_reg  out  1  jr.
- branch_addr  out  32  pc_plus_4_d + (sign_imm_d << 2), modulo 2^32.
- jump_addr  out  32  {pc_plus_4_d[31:28], instr_d[25:0], 2'b00}.
- jump_reg_addr  out  32  forwarded rs operand.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - instr_d=0 (nop), pc_plus_4_d=0, valid_d=0.
  - All registers cleared to 0.
  - Outputs follow combinationally: branch/jump/jump_reg=0, all addresses derived from zeros.
- Reset deassertion mid-operation: the first posedge after release loads IF/ID normally.
- IF/ID register, priority order:
  - rst_n=0 clears.
  - Otherwise stall_d=1 holds all fields.
  - Otherwise flush_d=1 loads instr_d=0, pc_plus_4_d=0, valid_d=0.
  - Otherwise loads instr_f, pc_plus_4_f, valid_d=1.
- flush_d = (branch | jump | jump_reg), evaluated in the same cycle. This kills the wrong-path instruction; the core has no delay slot.
- Latency: one cycle from instr_f to instr_d; all other outputs are combinational from instr_d and the register file.
- Register file:
  - Written at posedge when reg_write_w=1 and write_reg_w!=0.
  - Writes to $0 are ignored; $0 always reads 0.
  - Reads are combinational with write-through: if reg_write_w=1, write_reg_w==index and index!=0, the read returns result_w in the same cycle.
- Compare operands:
  - a = forward_a_d ? alu_out_m : rd1_d.
  - b = forward_b_d ? alu_out_m : rd2_d.
  - eq = (a==b), full 32-bit compare.
- Decode, gated by valid_d & ~stall_d:
  - op 6'b000100 (beq): branch = eq.
  - op 6'b000101 (bne): branch = ~eq.
  - op 6'b000010 / 6'b000011 (j/jal): jump = 1.
  - op 0 with funct 6'b001000 (jr): jump_reg = 1.
  - All other encodings: all three 0.
- At most one of branch/jump/jump_reg is 1 at a time.
- Stall + taken branch in the same cycle: outputs stay 0, no flush. The branch resolves on the first unstalled cycle.
- jump_reg_addr = a (forwarded rs).
- branch_addr wraps modulo 2^32. A negative offset is sign-extended before the shift, e.g. imm 0xFFFF -> -4.
- jal link write is not done here. rd_d/rt_d pass through; later stages handle it.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL);
  - FUNCT_JR;
  - instruction field-slice widths.
- One sub-module, reg_file: two async read ports, one sync write port, async active-low clear, write-through bypass, $0 hardwired.
- The IF/ID register and decode logic stay inline.

Test Plan:
- Reset clears state: assert rst_n=0 mid-stream with instr_f=0x1000_0003 -> instr_d=0, rd1_d=rd2_d=0, branch=jump=jump_reg=0 immediately, without waiting for a clock edge.
- Write-through read: write $5=0x1234_5678 (reg_write_w=1) in the same cycle instr_d=add $6,$5,$0 -> rd1_d=0x1234_5678 that cycle. A write of 0xFFFF_FFFF to $0 -> $0 still reads 0.
- beq taken with flush:
  - Setup: $1=$2=7, pc_plus_4_f=0x0000_0040, instr beq $1,$2,-2 (0x1022_FFFE).
  - Cycle after load: branch=1, branch_addr=0x0000_0038.
  - Next cycle: instr_d=0.
- bne with forwarding: $3=0, alu_out_m=9, forward_a_d=1, bne $3,$0,+1 -> branch=1, branch_addr=pc_plus_4_d+4. With forward_a_d=0 -> branch=0.
- jump and jr address formation:
  - j 0x0100_000 with pc_plus_4_d=0x9000_0004 -> jump=1, jump_addr=0x9040_0000.
  - jr $31 with $31=0x0000_0120 -> jump_reg=1, jump_reg_addr=0x0000_0120.
- Stall over a taken branch: stall_d=1 for 2 cycles over a taken beq -> instr_d held, branch=0 both cycles. On stall release: branch=1 for one cycle, then flush.
